// File: rtl/alu_pipe_mc.sv
// Registered-output ALU with valid/ready handshakes and a multicycle shift-add multiplier.
// Optional {N,Z,C,V} flags port is built only when ALU_FLAGS_EN is defined.
module alu_pipe_mc #(
    parameter int BITWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] Data_InA,
    input  logic [BITWIDTH-1:0] Data_InB,
    input  logic [3:0]          Opcode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] Data_OutC
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]          Flags
`endif
);
    localparam int SHW = $clog2(BITWIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [SHW-1:0]          cnt;
    logic [2*BITWIDTH-1:0]   acc, a_sh;
    logic [BITWIDTH-1:0]     b_sh;
    logic                    mul_hi;
    logic                    accept, is_mul;
    logic [SHW-1:0]          shamt;
    logic [BITWIDTH-1:0]     alu_res, mul_res;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !abort;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (Opcode == 4'h9) || (Opcode == 4'hA);
    assign shamt    = Data_InB[SHW-1:0];
    assign mul_res  = mul_hi ? acc[2*BITWIDTH-1:BITWIDTH] : acc[BITWIDTH-1:0];

    always_comb begin
        alu_res = '0;
        case (Opcode)
            4'h0: alu_res = Data_InA + Data_InB;
            4'h1: alu_res = Data_InA - Data_InB;
            4'h2: alu_res = Data_InA & Data_InB;
            4'h3: alu_res = Data_InA | Data_InB;
            4'h4: alu_res = Data_InA ^ Data_InB;
            4'h5: alu_res = ~Data_InA;
            4'h6: alu_res = Data_InA << shamt;
            4'h7: alu_res = Data_InA >> shamt;
            4'h8: alu_res = $unsigned($signed(Data_InA) >>> shamt);
            4'hB: alu_res = {{(BITWIDTH-1){1'b0}}, $signed(Data_InA) < $signed(Data_InB)};
            4'hC: alu_res = {{(BITWIDTH-1){1'b0}}, Data_InA < Data_InB};
            4'hD: alu_res = {{(BITWIDTH-1){1'b0}}, Data_InA == Data_InB};
            4'hE: alu_res = Data_InA;
            4'hF: alu_res = Data_InB;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
                S_MUL:  if (cnt == '0) state_nxt = S_DONE;
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            Data_OutC <= '0;
            cnt       <= '0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            mul_hi    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                out_valid <= 1'b0;
                cnt       <= '0;
            end else if (accept && is_mul) begin
                // accept implies any held result is consumed this edge
                a_sh      <= {{BITWIDTH{1'b0}}, Data_InA};
                b_sh      <= Data_InB;
                acc       <= '0;
                mul_hi    <= (Opcode == 4'hA);
                cnt       <= SHW'(BITWIDTH - 1);
                out_valid <= 1'b0;
            end else if (accept) begin
                Data_OutC <= alu_res;
                out_valid <= 1'b1;
            end else if (state == S_MUL) begin
                acc  <= acc + (b_sh[0] ? a_sh : '0);
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                if (cnt != '0) cnt <= cnt - SHW'(1);
            end else if (state == S_DONE) begin
                Data_OutC <= mul_res;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    localparam logic [BITWIDTH-1:0] MSB_BIT = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [BITWIDTH-1:0] LSB_BIT = {{(BITWIDTH-1){1'b0}}, 1'b1};

    logic flag_c, flag_v;

    // Shift carry is the last bit shifted out; ASR and SHR agree since shamt <= BITWIDTH-1.
    always_comb begin
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (Opcode)
            4'h0: begin
                flag_c = alu_res < Data_InA;
                flag_v = (Data_InA[BITWIDTH-1] == Data_InB[BITWIDTH-1]) &&
                         (alu_res[BITWIDTH-1] != Data_InA[BITWIDTH-1]);
            end
            4'h1: begin
                flag_c = Data_InA < Data_InB;
                flag_v = (Data_InA[BITWIDTH-1] != Data_InB[BITWIDTH-1]) &&
                         (alu_res[BITWIDTH-1] != Data_InA[BITWIDTH-1]);
            end
            4'h6: flag_c = (shamt != '0) &&
                           (((Data_InA << (shamt - SHW'(1))) & MSB_BIT) != '0);
            4'h7, 4'h8: flag_c = (shamt != '0) &&
                           (((Data_InA >> (shamt - SHW'(1))) & LSB_BIT) != '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Flags <= '0;
        end else if (!abort) begin
            if (accept && !is_mul)
                Flags <= {alu_res[BITWIDTH-1], alu_res == '0, flag_c, flag_v};
            else if (state == S_DONE)
                Flags <= {mul_res[BITWIDTH-1], mul_res == '0,
                          acc[2*BITWIDTH-1:BITWIDTH] != '0, 1'b0};
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Self-checking bench for alu_pipe_mc: vector table, multicycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_alu_pipe_mc;
    logic        clk = 1'b0;
    logic        rst, abort, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] Data_InA, Data_InB, Data_OutC;
    logic [3:0]  Opcode;
`ifdef ALU_FLAGS_EN
    logic [3:0]  flags;
`endif

    int checks = 0;
    int errors = 0;

    alu_pipe_mc #(.BITWIDTH(16)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .Data_InA(Data_InA), .Data_InB(Data_InB), .Opcode(Opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .Data_OutC(Data_OutC)
`ifdef ALU_FLAGS_EN
        , .Flags(flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the opcode definitions.
    function automatic logic [15:0] ref_alu(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        int unsigned        sh;
        logic [31:0]        p;
        logic signed [15:0] sa;
        sh = int'(b[3:0]);
        p  = {16'h0, a} * {16'h0, b};
        sa = a;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~a;
            4'h6: return a << sh;
            4'h7: return a >> sh;
            4'h8: return sa >>> sh;
            4'h9: return p[15:0];
            4'hA: return p[31:16];
            4'hB: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'hC: return (a < b) ? 16'd1 : 16'd0;
            4'hD: return (a == b) ? 16'd1 : 16'd0;
            4'hE: return a;
            default: return b;
        endcase
    endfunction

    task automatic mul_seq(logic [3:0] op, logic [15:0] exp, string nm);
        int n, busy;
        in_valid = 1; Opcode = op; Data_InA = 16'h0081; Data_InB = 16'h801F; out_ready = 1;
        #1 chk({nm, "_accept_rdy"}, in_ready, 1);
        tick();
        // operands offered while busy must be ignored
        Opcode = 4'hF; Data_InB = 16'hDEAD;
        n = 0; busy = 0;
        while (!out_valid && n < 40) begin
            if (!in_ready) busy++;
            tick();
            n++;
        end
        in_valid = 0;
        chk({nm, "_latency"}, n, 17);
        chk({nm, "_busy_cycles"}, busy, 17);
        chk({nm, "_result"}, Data_OutC, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          seen;
        int          busy;
        logic        m_valid, exp_rdy;
        logic [15:0] m_data, pend, r;

        tbl[0]  = '{4'h0, 16'h0081, 16'h801F, 16'h80A0};
        tbl[1]  = '{4'h1, 16'h0081, 16'h801F, 16'h8062};
        tbl[2]  = '{4'h2, 16'h0081, 16'h801F, 16'h0001};
        tbl[3]  = '{4'h3, 16'h0081, 16'h801F, 16'h809F};
        tbl[4]  = '{4'h4, 16'h0081, 16'h801F, 16'h809E};
        tbl[5]  = '{4'h5, 16'h0081, 16'h801F, 16'hFF7E};
        tbl[6]  = '{4'h6, 16'h0081, 16'h801F, 16'h8000};
        tbl[7]  = '{4'h7, 16'h0081, 16'h801F, 16'h0000};
        tbl[8]  = '{4'h8, 16'h8000, 16'h801F, 16'hFFFF};
        tbl[9]  = '{4'hB, 16'h0081, 16'h801F, 16'h0000};
        tbl[10] = '{4'hC, 16'h0081, 16'h801F, 16'h0001};
        tbl[11] = '{4'hD, 16'h0081, 16'h801F, 16'h0000};
        tbl[12] = '{4'hE, 16'h0081, 16'h801F, 16'h0081};
        tbl[13] = '{4'hF, 16'h0081, 16'h801F, 16'h801F};
        tbl[14] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000};
        tbl[15] = '{4'hB, 16'h8000, 16'h0001, 16'h0001};
        tbl[16] = '{4'hD, 16'h1234, 16'h1234, 16'h0001};
        tbl[17] = '{4'h6, 16'h1234, 16'h0010, 16'h1234};

        rst = 1; abort = 0; in_valid = 0; out_ready = 0;
        Data_InA = 0; Data_InB = 0; Opcode = 0;
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data", Data_OutC, 0);
        rst = 0;
        tick();
        chk("idle_in_ready", in_ready, 1);

        // back-to-back single-cycle ops, one result per cycle
        out_ready = 1;
        for (int i = 0; i < 18; i++) begin
            in_valid = 1; Opcode = tbl[i].op; Data_InA = tbl[i].a; Data_InB = tbl[i].b;
            #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_op%0h_res", i, tbl[i].op), Data_OutC, tbl[i].res);
        end
        in_valid = 0;
        tick();
        chk("drain_valid", out_valid, 0);

        mul_seq(4'h9, 16'h8F9F, "mul_lo");
`ifdef ALU_FLAGS_EN
        chk("mul_lo_flags", flags, 4'hA);
`endif
        mul_seq(4'hA, 16'h0040, "mul_hi");

        // output hold under backpressure
        in_valid = 1; Opcode = 4'h0; Data_InA = 16'h0081; Data_InB = 16'h801F; out_ready = 1;
        tick();
        out_ready = 0; Opcode = 4'hE; Data_InA = 16'h5555;
`ifdef ALU_FLAGS_EN
        chk("add_flags", flags, 4'h8);
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d_data", i), Data_OutC, 16'h80A0);
            chk($sformatf("hold%0d_valid", i), out_valid, 1);
            chk($sformatf("hold%0d_in_ready", i), in_ready, 0);
            tick();
        end
        out_ready = 1;
        #1 chk("release_in_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("release_valid", out_valid, 1);
        chk("release_data", Data_OutC, 16'h5555);

        // abort on MUL cycle 5
        in_valid = 1; Opcode = 4'h9; Data_InA = 16'h0003; Data_InB = 16'h0005;
        tick();
        in_valid = 0;
        repeat (4) tick();
        abort = 1;
        #1 chk("abort_in_ready", in_ready, 0);
        tick();
        abort = 0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_data_kept", Data_OutC, 16'h5555);
        chk("abort_in_ready_after", in_ready, 1);
        seen = 0;
        repeat (20) begin tick(); if (out_valid) seen++; end
        chk("abort_no_stale", seen, 0);

        // asynchronous reset mid-MUL
        in_valid = 1; Opcode = 4'h9; Data_InA = 16'h0003; Data_InB = 16'h0005;
        tick();
        in_valid = 0;
        repeat (3) tick();
        rst = 1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", Data_OutC, 0);
        #1 rst = 0;
        tick();
        chk("rst_in_ready", in_ready, 1);
        seen = 0;
        repeat (20) begin tick(); if (out_valid) seen++; end
        chk("rst_no_stale", seen, 0);

        // randomized run against the transaction model
        m_valid = 0; m_data = 0; busy = 0; pend = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            Opcode    = 4'($urandom_range(0, 15));
            Data_InA  = 16'($urandom);
            Data_InB  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 40) == 0);
            #1;
            exp_rdy = (busy == 0) && (!m_valid || out_ready) && !abort;
            chk("rand_in_ready", in_ready, exp_rdy);
            if (abort) begin
                m_valid = 0; busy = 0;
            end else if (in_valid && exp_rdy) begin
                r = ref_alu(Opcode, Data_InA, Data_InB);
                if (Opcode == 4'h9 || Opcode == 4'hA) begin
                    busy = 17; pend = r; m_valid = 0;
                end else begin
                    m_data = r; m_valid = 1;
                end
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin m_data = pend; m_valid = 1; end
            end else if (out_ready) begin
                m_valid = 0;
            end
            tick();
            chk("rand_out_valid", out_valid, m_valid);
            chk("rand_data", Data_OutC, m_data);
        end
        in_valid = 0; abort = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
